branch_predict_2lv: RTL and testbench

Parametrised two-level local-history branch predictor for the 5-stage PipelineMIPS core. A per-PC branch history table (BHT) indexes a shared pattern history table (PHT) of 2-bit saturating counters. The lookup uses pcF, registers the prediction into D, and qualifies it with D-stage branch decode. Training uses the resolved outcome at M. The block also keeps branch and misprediction statistics counters.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_sat2.sv | 23 ++
 rtl/branch_predict_2lv.sv | 134 +++++++++++++
 tb/tb_branch_predict_2lv.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared constants for the two-level branch predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST) and PHT reset value
//   - MIPS opcode constants used by the D-stage branch decode
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } sat2_t;

    localparam sat2_t      PHT_RESET      = WT;

    localparam logic [5:0] EXE_REGIMM     = 6'b000001;
    // op[5:2] prefixes: beq/bne/blez/bgtz and their branch-likely forms
    localparam logic [3:0] OP_BRANCH_PFX  = 4'b0001;
    localparam logic [3:0] OP_BRANCHL_PFX = 4'b0101;

endpackage

// File: rtl/bp_sat2.sv
// bp_sat2: combinational next-state function of a 2-bit saturating counter.
// Ports:
//   cur   in  2  current counter value
//   taken in  1  resolved branch direction
//   next  out 2  counter after training (saturates at SNT and ST)
module bp_sat2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = cur;
        if (taken && (cur != ST)) begin
            next = cur + 2'd1;
        end else if (!taken && (cur != SNT)) begin
            next = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_2lv.sv
// branch_predict_2lv: two-level local-history branch predictor.
// A per-PC branch history table (BHT) selects a 2-bit counter in a shared
// pattern history table (PHT). Lookup on pcF, prediction registered into D,
// training with the resolved outcome at M. Also counts retired branches and
// mispredictions (saturating).
// Build option: define BP_GSHARE_EN to XOR the PC into the PHT index.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   flushD, stallD       D-stage prediction register control (flush wins)
//   instrD               instruction in D (branch decode)
//   pcF                  fetch PC used for lookup
//   pcM, branchM         PC / valid strobe of the branch retiring in M
//   actual_takeM         resolved direction in M
//   pred_takeM           prediction that travelled with the branch in M
//   branchD, branchL_D   D instruction is a conditional / likely branch
//   pred_takeD           predicted taken for the D instruction
//   branch_cnt           retired conditional branches
//   mispred_cnt          retired mispredicted branches
module branch_predict_2lv
    import bp_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 10,
    parameter int unsigned HIST_LEN  = 6,
    parameter int unsigned PHT_DEPTH = 6,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flushD,
    input  logic             stallD,
    input  logic [31:0]      instrD,
    input  logic [31:0]      pcF,
    input  logic [31:0]      pcM,
    input  logic             branchM,
    input  logic             actual_takeM,
    input  logic             pred_takeM,
    output logic             branchD,
    output logic             branchL_D,
    output logic             pred_takeD,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned BHT_N = 1 << BHT_DEPTH;
    localparam int unsigned PHT_N = 1 << PHT_DEPTH;

    logic [HIST_LEN-1:0]  bht [BHT_N];
    logic [1:0]           pht [PHT_N];

    logic [BHT_DEPTH-1:0] bht_idx_f, bht_idx_m;
    logic [HIST_LEN-1:0]  hist_f, hist_m, hist_next;
    logic [PHT_DEPTH-1:0] pc_hash_f, pc_hash_m;
    logic [PHT_DEPTH-1:0] pht_idx_f, pht_idx_m;
    logic [1:0]           pht_cur_m, pht_next_m;
    logic                 pred_takeF, pred_takeF_r;

    // ---------------- D-stage decode ----------------
    logic [5:0] op;
    assign op = instrD[31:26];

    always_comb begin
        branchD   = ((op == EXE_REGIMM) && (instrD[19:18] == 2'b00))
                  || (op[5:2] == OP_BRANCH_PFX)
                  || (op[5:2] == OP_BRANCHL_PFX);
        branchL_D = ((op == EXE_REGIMM) && (instrD[19:17] == 3'b001))
                  || (op[5:2] == OP_BRANCHL_PFX);
    end

    // ---------------- index generation ----------------
    assign bht_idx_f = pcF[BHT_DEPTH+1:2];
    assign bht_idx_m = pcM[BHT_DEPTH+1:2];
    assign hist_f    = bht[bht_idx_f];
    assign hist_m    = bht[bht_idx_m];

`ifdef BP_GSHARE_EN
    assign pc_hash_f = pcF[PHT_DEPTH+1:2];
    assign pc_hash_m = pcM[PHT_DEPTH+1:2];
`else
    assign pc_hash_f = '0;
    assign pc_hash_m = '0;
`endif

    assign pht_idx_f = PHT_DEPTH'(hist_f) ^ pc_hash_f;
    assign pht_idx_m = PHT_DEPTH'(hist_m) ^ pc_hash_m;

    assign pred_takeF = pht[pht_idx_f][1];

    // ---------------- training ----------------
    // Truncating {h, taken} keeps h[HIST_LEN-2:0]; also covers HIST_LEN == 1.
    assign hist_next = HIST_LEN'({hist_m, actual_takeM});
    assign pht_cur_m = pht[pht_idx_m];

    bp_sat2 u_sat2 (
        .cur   (pht_cur_m),
        .taken (actual_takeM),
        .next  (pht_next_m)
    );

    // Tables are read combinationally above; writes land at the edge, so a
    // same-cycle lookup sees the pre-update entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_N; i++) bht[i] <= '0;
            for (int unsigned j = 0; j < PHT_N; j++) pht[j] <= PHT_RESET;
        end else if (branchM) begin
            bht[bht_idx_m] <= hist_next;
            pht[pht_idx_m] <= pht_next_m;
        end
    end

    // ---------------- D-stage prediction register ----------------
    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            pred_takeF_r <= 1'b0;
        end else if (!stallD) begin
            pred_takeF_r <= pred_takeF;
        end
    end

    assign pred_takeD = branchD & pred_takeF_r;

    // ---------------- statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (branchM) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if ((pred_takeM != actual_takeM) && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_2lv.sv
// tb_branch_predict_2lv: directed, self-checking bench for branch_predict_2lv.
// A second instance with CNT_W=4 shares all inputs for counter saturation.
// All PCs used have pc[7:2]==0 so expectations hold with or without
// BP_GSHARE_EN.
module tb_branch_predict_2lv;

    localparam logic [31:0] BEQ = 32'h1022_0000;

    logic        clk, rst, flushD, stallD, branchM, actual_takeM, pred_takeM;
    logic [31:0] instrD, pcF, pcM;
    logic        branchD, branchL_D, pred_takeD;
    logic [31:0] branch_cnt, mispred_cnt;
    logic        branchD4, branchL_D4, pred_takeD4;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    int n_vec = 0;
    int n_err = 0;

    branch_predict_2lv u_dut (
        .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD),
        .instrD(instrD), .pcF(pcF), .pcM(pcM), .branchM(branchM),
        .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
        .branchD(branchD), .branchL_D(branchL_D), .pred_takeD(pred_takeD),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_predict_2lv #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD),
        .instrD(instrD), .pcF(pcF), .pcM(pcM), .branchM(branchM),
        .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
        .branchD(branchD4), .branchL_D(branchL_D4), .pred_takeD(pred_takeD4),
        .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        bd;
        logic        bl;
        logic        pd;
    } dec_vec_t;

    dec_vec_t dec_tab[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic act, input logic pm);
        branchM = 1'b1; pcM = pc; actual_takeM = act; pred_takeM = pm;
    endtask

    // hand-derived predictions for alternating T,N,T,N... on pc 0x200
    logic exp_alt[20];

    initial begin
        dec_tab[0]  = '{"beq",     32'h1022_0000, 1'b1, 1'b0, 1'b1};
        dec_tab[1]  = '{"bne",     32'h1422_0000, 1'b1, 1'b0, 1'b1};
        dec_tab[2]  = '{"blez",    32'h1820_0000, 1'b1, 1'b0, 1'b1};
        dec_tab[3]  = '{"bgtz",    32'h1C20_0000, 1'b1, 1'b0, 1'b1};
        dec_tab[4]  = '{"beql",    32'h5022_0000, 1'b1, 1'b1, 1'b1};
        dec_tab[5]  = '{"bnel",    32'h5422_0000, 1'b1, 1'b1, 1'b1};
        dec_tab[6]  = '{"bltz",    32'h0420_0000, 1'b1, 1'b0, 1'b1};
        dec_tab[7]  = '{"bgez",    32'h0421_0000, 1'b1, 1'b0, 1'b1};
        dec_tab[8]  = '{"bltzl",   32'h0422_0000, 1'b1, 1'b1, 1'b1};
        dec_tab[9]  = '{"bgezl",   32'h0423_0000, 1'b1, 1'b1, 1'b1};
        dec_tab[10] = '{"bltzal",  32'h0430_0000, 1'b1, 1'b0, 1'b1};
        dec_tab[11] = '{"bgezall", 32'h0433_0000, 1'b1, 1'b1, 1'b1};
        dec_tab[12] = '{"tgei",    32'h0428_0000, 1'b0, 1'b0, 1'b0};
        dec_tab[13] = '{"add",     32'h0022_1820, 1'b0, 1'b0, 1'b0};
        dec_tab[14] = '{"j",       32'h0800_0010, 1'b0, 1'b0, 1'b0};
        dec_tab[15] = '{"addi",    32'h2022_0005, 1'b0, 1'b0, 1'b0};
        dec_tab[16] = '{"lw",      32'h8C22_0000, 1'b0, 1'b0, 1'b0};

        for (int k = 0; k < 20; k++) exp_alt[k] = (k % 2 == 0);
        exp_alt[0] = 1'b0;
        for (int k = 1; k < 7; k++) exp_alt[k] = 1'b1;

        rst = 1'b1; flushD = 1'b0; stallD = 1'b0; instrD = BEQ;
        pcF = 32'h100; pcM = 32'h0; branchM = 1'b0;
        actual_takeM = 1'b0; pred_takeM = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("reset_pred", {31'b0, pred_takeD}, 0);
        chk("reset_bcnt", branch_cnt, 0);
        chk("reset_mcnt", mispred_cnt, 0);
        rst = 1'b0;

        // ---- first lookup: PHT reset is WT ----
        step();
        chk("first_pred", {31'b0, pred_takeD}, 1);
        chk("first_bcnt", branch_cnt, 0);

        // ---- four not-taken updates of 0x100 saturate PHT[0] at SNT ----
        upd(32'h100, 1'b0, 1'b1);
        step();
        chk("cnt_latency_b", branch_cnt, 1);
        chk("cnt_latency_m", mispred_cnt, 1);
        for (int k = 0; k < 3; k++) step();
        branchM = 1'b0;
        step();
        chk("nt_sat_pred", {31'b0, pred_takeD}, 0);
        chk("nt_sat_bcnt", branch_cnt, 4);
        chk("nt_sat_mcnt", mispred_cnt, 4);

        // ---- alternating outcome learning on pc 0x200 ----
        for (int k = 0; k < 20; k++) begin
            pcF = 32'h200; branchM = 1'b0;
            step();
            chk($sformatf("alt_pred_%0d", k), {31'b0, pred_takeD}, {31'b0, exp_alt[k]});
            upd(32'h200, (k % 2 == 0), exp_alt[k]);
            step();
        end
        branchM = 1'b0;
        step();
        chk("alt_bcnt", branch_cnt, 24);
        chk("alt_mcnt", mispred_cnt, 8);

        // ---- same-cycle lookup/update: PHT entry shared via history 0 ----
        pcF = 32'h400; upd(32'h300, 1'b1, 1'b0);
        step();
        chk("same_pht_old", {31'b0, pred_takeD}, 0);
        branchM = 1'b0;
        step();
        chk("same_pht_new", {31'b0, pred_takeD}, 1);
        // same BHT entry: lookup must use the old history
        pcF = 32'h300; upd(32'h300, 1'b0, 1'b0);
        step();
        chk("same_bht_old", {31'b0, pred_takeD}, 0);
        branchM = 1'b0;
        step();
        chk("same_bht_new", {31'b0, pred_takeD}, 1);

        // ---- flush beats stall; stall holds while pcF moves ----
        flushD = 1'b1; stallD = 1'b1;
        step();
        chk("flush_stall", {31'b0, pred_takeD}, 0);
        flushD = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pcF = (k == 0) ? 32'h300 : (k == 1) ? 32'h200 : 32'h400;
            step();
            chk($sformatf("stall_hold_%0d", k), {31'b0, pred_takeD}, 0);
        end
        stallD = 1'b0;
        step();
        chk("stall_release", {31'b0, pred_takeD}, 1);

        // ---- decode sweep (prediction register is 1, pcF=0x400) ----
        for (int i = 0; i < 17; i++) begin
            instrD = dec_tab[i].instr;
            step();
            chk({"dec_bd_", dec_tab[i].name}, {31'b0, branchD},    {31'b0, dec_tab[i].bd});
            chk({"dec_bl_", dec_tab[i].name}, {31'b0, branchL_D},  {31'b0, dec_tab[i].bl});
            chk({"dec_pd_", dec_tab[i].name}, {31'b0, pred_takeD}, {31'b0, dec_tab[i].pd});
        end
        instrD = BEQ;

        // ---- narrow counters already saturated, wide ones not ----
        chk("w4_bcnt_pre", {28'b0, branch_cnt4}, 15);
        chk("w4_mcnt_pre", {28'b0, mispred_cnt4}, 9);
        chk("w32_bcnt_pre", branch_cnt, 26);

        // ---- mid-run reset clears everything ----
        rst = 1'b1;
        step();
        chk("rst2_pred", {31'b0, pred_takeD}, 0);
        chk("rst2_bcnt", branch_cnt, 0);
        chk("rst2_mcnt4", {28'b0, mispred_cnt4}, 0);
        rst = 1'b0;

        // ---- 20 mispredicted branches: CNT_W=4 saturates at 15 ----
        for (int k = 0; k < 20; k++) begin
            upd(32'h100, 1'b0, 1'b1);
            step();
            if (k == 14) chk("w4_bcnt_15", {28'b0, branch_cnt4}, 15);
        end
        branchM = 1'b0;
        step();
        chk("w4_bcnt_sat", {28'b0, branch_cnt4}, 15);
        chk("w4_mcnt_sat", {28'b0, mispred_cnt4}, 15);
        chk("w32_bcnt_20", branch_cnt, 20);
        chk("w32_mcnt_20", mispred_cnt, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
